// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: shared types and constants for the execute-stage integer core.
//   alu_op_e  : ALU opcode encoding (4 bits)
//   mul_op_e  : multiply/divide opcode encoding (4 bits)
//   u64 / u32 : plain unsigned data words
//   DIV_ITERS : restoring-divider iteration count
//   sext32()  : sign-extend a 32-bit word to 64 bits
package alu_mul_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam int unsigned DIV_ITERS = 64;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    MulMul   = 4'd0,
    MulH     = 4'd1,
    MulHsu   = 4'd2,
    MulHu    = 4'd3,
    MulDiv   = 4'd4,
    MulDivu  = 4'd5,
    MulRem   = 4'd6,
    MulRemu  = 4'd7,
    MulW     = 4'd8,
    MulDivw  = 4'd9,
    MulDivuw = 4'd10,
    MulRemw  = 4'd11,
    MulRemuw = 4'd12
  } mul_op_e;

  function automatic u64 sext32(input u32 v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_mul_div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
// Operands arrive already extended to 64 bits; signed operation works on magnitudes and
// fixes signs at the end (quotient negative if signs differ, remainder takes dividend sign).
// Divide-by-zero and signed overflow are handled by the caller and never started here.
//   clk_i, rst_i       : clock, synchronous active-high reset (aborts a running divide)
//   start_i            : load operands and begin (ignored while busy)
//   dividend_i/divisor_i, signed_i : operands and signedness
//   busy_o             : divide in progress
//   done_o             : the coming edge retires the last iteration
//   quotient_o/remainder_o : final results, valid while done_o is high
module div_iter
  import alu_mul_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  u64   dividend_i,
  input  u64   divisor_i,
  input  logic signed_i,
  output logic busy_o,
  output logic done_o,
  output u64   quotient_o,
  output u64   remainder_o
);

  logic        busy_q, busy_d;
  logic [6:0]  cnt_q, cnt_d;
  u64          quo_q, quo_d;
  u64          rem_q, rem_d;
  u64          dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        a_neg, b_neg, last;
  logic [64:0] rem_shift, diff;
  u64          quo_step, rem_step;

  // One restoring step: quo_q shifts the dividend out MSB-first and the quotient in LSB-first.
  always_comb begin
    rem_shift = {rem_q, quo_q[63]};
    diff      = rem_shift - {1'b0, dvs_q};
    if (diff[64]) begin
      rem_step = rem_shift[63:0];
      quo_step = {quo_q[62:0], 1'b0};
    end else begin
      rem_step = diff[63:0];
      quo_step = {quo_q[62:0], 1'b1};
    end
  end

  assign last = busy_q && (cnt_q == 7'(DIV_ITERS - 1));

  always_comb begin
    a_neg  = signed_i & dividend_i[63];
    b_neg  = signed_i & divisor_i[63];
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (!busy_q && start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = a_neg ? -dividend_i : dividend_i;
      rem_d  = '0;
      dvs_d  = b_neg ? -divisor_i : divisor_i;
      negq_d = a_neg ^ b_neg;
      negr_d = a_neg;
    end else if (busy_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 7'd1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = last;
  assign quotient_o  = negq_q ? -quo_step : quo_step;
  assign remainder_o = negr_q ? -rem_step : rem_step;

endmodule

// File: rtl/alu_mul.sv
// alu_mul: execute-stage integer core. Combinational RV64I ALU plus registered RV64M
// multiply/divide unit.
// Build option: ALU_MUL_DIV_EN enables the iterative divider; without it divide/remainder
// ops write 0 in one cycle and busy is tied low.
//   clk, rst        : clock, synchronous active-high reset
//   en, newOp       : request qualifiers; start = en & newOp & ~busy
//   ia, ib          : 64-bit operands
//   aluOp, mulOp    : opcodes
//   aluOut/aluOut32 : combinational ALU results (64-bit and low-word)
//   mulOut          : registered multiply/divide result, held until next completion
//   busy            : divide in progress
module alu_mul
  import alu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        newOp,
  input  logic [63:0] ia,
  input  logic [63:0] ib,
  input  logic [3:0]  aluOp,
  input  logic [3:0]  mulOp,
  output logic [63:0] aluOut,
  output logic [31:0] aluOut32,
  output logic [63:0] mulOut,
  output logic        busy
);

  alu_op_e alu_op;
  mul_op_e mul_op;
  u32      a32, b32;

  assign alu_op = alu_op_e'(aluOp);
  assign mul_op = mul_op_e'(mulOp);
  assign a32    = ia[31:0];
  assign b32    = ib[31:0];

  // ---------------- ALU ----------------
  always_comb begin
    aluOut   = '0;
    aluOut32 = '0;
    case (alu_op)
      AluAdd:  begin aluOut = ia + ib;  aluOut32 = a32 + b32; end
      AluSub:  begin aluOut = ia - ib;  aluOut32 = a32 - b32; end
      AluAnd:  begin aluOut = ia & ib;  aluOut32 = a32 & b32; end
      AluOr:   begin aluOut = ia | ib;  aluOut32 = a32 | b32; end
      AluXor:  begin aluOut = ia ^ ib;  aluOut32 = a32 ^ b32; end
      AluSll:  begin aluOut = ia << ib[5:0]; aluOut32 = a32 << ib[4:0]; end
      AluSrl:  begin aluOut = ia >> ib[5:0]; aluOut32 = a32 >> ib[4:0]; end
      AluSra: begin
        aluOut   = u64'($signed(ia) >>> ib[5:0]);
        aluOut32 = u32'($signed(a32) >>> ib[4:0]);
      end
      AluSlt: begin
        aluOut   = {63'd0, $signed(ia) < $signed(ib)};
        aluOut32 = {31'd0, $signed(a32) < $signed(b32)};
      end
      AluSltu: begin
        aluOut   = {63'd0, ia < ib};
        aluOut32 = {31'd0, a32 < b32};
      end
      default: ;
    endcase
  end

  // ---------------- Multiplier ----------------
  // One 128-bit product; operand extension picks the signedness so every variant shares it.
  logic         a_sgn, b_sgn;
  logic [127:0] mul_a, mul_b, prod;

  assign a_sgn = (mul_op == MulH) || (mul_op == MulHsu);
  assign b_sgn = (mul_op == MulH);
  assign mul_a = {{64{a_sgn & ia[63]}}, ia};
  assign mul_b = {{64{b_sgn & ib[63]}}, ib};
  assign prod  = mul_a * mul_b;

  logic start;
  logic div_go;    // start goes to the iterative divider instead of writing immediately
  logic div_done;
  u64   div_res;
  u64   imm_res;
  u64   mul_out_q, mul_out_d;

  assign start = en & newOp & ~busy;

`ifdef ALU_MUL_DIV_EN
  logic is_div, div_w, div_sgn, div_rem, div_zero, div_ovf, div_busy;
  logic div_w_q, div_w_d, div_rem_q, div_rem_d;
  u64   div_a, div_b, spec_res, div_quo, div_remr, raw_res;

  always_comb begin
    is_div  = mul_op inside {MulDiv, MulDivu, MulRem, MulRemu,
                             MulDivw, MulDivuw, MulRemw, MulRemuw};
    div_w   = mul_op inside {MulDivw, MulDivuw, MulRemw, MulRemuw};
    div_sgn = mul_op inside {MulDiv, MulRem, MulDivw, MulRemw};
    div_rem = mul_op inside {MulRem, MulRemu, MulRemw, MulRemuw};
    if (div_w) begin
      div_a = div_sgn ? sext32(a32) : {32'd0, a32};
      div_b = div_sgn ? sext32(b32) : {32'd0, b32};
    end else begin
      div_a = ia;
      div_b = ib;
    end
    div_zero = (div_b == '0);
    // W operands are already sign-extended, so the most-negative value is the extended one.
    div_ovf  = div_sgn && (div_b == '1) &&
               (div_a == (div_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (div_zero) begin
      spec_res = div_rem ? (div_w ? sext32(a32) : ia) : '1;
    end else begin
      spec_res = div_rem ? '0 : div_a;
    end
  end

  assign div_go = start && is_div && !div_zero && !div_ovf;

  always_comb begin
    div_w_d   = div_w_q;
    div_rem_d = div_rem_q;
    if (div_go) begin
      div_w_d   = div_w;
      div_rem_d = div_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_w_q   <= 1'b0;
      div_rem_q <= 1'b0;
    end else begin
      div_w_q   <= div_w_d;
      div_rem_q <= div_rem_d;
    end
  end

  div_iter u_div (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (div_go),
    .dividend_i  (div_a),
    .divisor_i   (div_b),
    .signed_i    (div_sgn),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_remr)
  );

  assign raw_res = div_rem_q ? div_remr : div_quo;
  assign div_res = div_w_q ? sext32(raw_res[31:0]) : raw_res;
  assign busy    = div_busy;
`else
  assign div_go   = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
  assign busy     = 1'b0;
`endif

  // Result written on the start edge (multiplies, unused ops, divide special cases).
  always_comb begin
    imm_res = '0;
    case (mul_op)
      MulMul:             imm_res = prod[63:0];
      MulH, MulHsu, MulHu: imm_res = prod[127:64];
      MulW:               imm_res = sext32(prod[31:0]);
`ifdef ALU_MUL_DIV_EN
      MulDiv, MulDivu, MulRem, MulRemu,
      MulDivw, MulDivuw, MulRemw, MulRemuw: imm_res = spec_res;
`endif
      default: ;
    endcase
  end

  always_comb begin
    mul_out_d = mul_out_q;
    if (div_done) begin
      mul_out_d = div_res;
    end else if (start && !div_go) begin
      mul_out_d = imm_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mul_out_q <= '0;
    else     mul_out_q <= mul_out_d;
  end

  assign mulOut = mul_out_q;

endmodule

// File: tb/tb_alu_mul.sv
module tb_alu_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        newOp = 1'b0;
  logic [63:0] ia = '0;
  logic [63:0] ib = '0;
  logic [3:0]  aluOp = '0;
  logic [3:0]  mulOp = '0;
  logic [63:0] aluOut;
  logic [31:0] aluOut32;
  logic [63:0] mulOut;
  logic        busy;

`ifdef ALU_MUL_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  alu_mul dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .newOp    (newOp),
    .ia       (ia),
    .ib       (ib),
    .aluOp    (aluOp),
    .mulOp    (mulOp),
    .aluOut   (aluOut),
    .aluOut32 (aluOut32),
    .mulOut   (mulOut),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e64;
    logic [31:0] e32;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          multi;
  } mul_vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  alu_vec_t av[14];
  mul_vec_t mv[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_div_op(input logic [3:0] op);
    return ((op >= 4'd4) && (op <= 4'd7)) || ((op >= 4'd9) && (op <= 4'd12));
  endfunction

  // Drive one request, scramble inputs after the start edge, then wait for and check the result.
  task automatic run_mul(input string name, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input bit multi);
    int n;
    logic [63:0] e;
    bit m;
    m = multi && DivEn;
    @(negedge clk);
    en = 1'b1; newOp = 1'b1; mulOp = op; ia = a; ib = b;
    sb.push_back((!DivEn && is_div_op(op)) ? 64'd0 : exp);
    @(posedge clk); #1;
    en = 1'b0;
    ia = {$urandom, $urandom};
    ib = {$urandom, $urandom};
    mulOp = 4'($urandom_range(0, 15));
    check({name, "_busy"}, {63'd0, busy}, {63'd0, m});
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m) check({name, "_cycles"}, 64'(n), 64'd64);
    e = sb.pop_front();
    check(name, mulOut, e);
  endtask

  initial begin
    int n;

    av[0]  = '{4'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE};
    av[1]  = '{4'd7, 64'h8000_0000_0000_0000, 64'h41, 64'hC000_0000_0000_0000, 32'h0};
    av[2]  = '{4'd0, 64'h0000_0001_FFFF_FFFF, 64'd1, 64'h0000_0002_0000_0000, 32'h0};
    av[3]  = '{4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
               64'hF000_F000_F000_F000, 32'hF000_F000};
    av[4]  = '{4'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
               64'hFFF0_FFF0_FFF0_FFF0, 32'hFFF0_FFF0};
    av[5]  = '{4'd4, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
               64'h0FF0_0FF0_0FF0_0FF0, 32'h0FF0_0FF0};
    av[6]  = '{4'd5, 64'd1, 64'h3F, 64'h8000_0000_0000_0000, 32'h8000_0000};
    av[7]  = '{4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h24, 64'h0000_0000_0FFF_FFFF, 32'h0FFF_FFFF};
    av[8]  = '{4'd7, 64'h0000_0000_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 32'hF800_0000};
    av[9]  = '{4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 32'd1};
    av[10] = '{4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'd0};
    av[11] = '{4'd8, 64'h0000_0000_8000_0000, 64'd1, 64'd0, 32'd1};
    av[12] = '{4'd12, 64'd5, 64'd7, 64'd0, 32'd0};
    av[13] = '{4'd9, 64'd1, 64'h0000_0001_0000_0000, 64'd1, 32'd0};

    mv[0]  = '{4'd1, '1, '1, 64'd0, 1'b0};
    mv[1]  = '{4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    mv[2]  = '{4'd0, 64'd6, 64'd7, 64'd42, 1'b0};
    mv[3]  = '{4'd2, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    mv[4]  = '{4'd8, 64'h1_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 1'b0};
    mv[5]  = '{4'd4, -64'sd20, 64'd3, -64'sd6, 1'b1};
    mv[6]  = '{4'd6, -64'sd20, 64'd3, -64'sd2, 1'b1};
    mv[7]  = '{4'd5, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    mv[8]  = '{4'd11, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0};
    mv[9]  = '{4'd9, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0};
    mv[10] = '{4'd7, 64'd100, 64'd0, 64'd100, 1'b0};
    mv[11] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h0000_0000_7FFF_FFF8, 1'b1};
    mv[12] = '{4'd14, 64'd9, 64'd9, 64'd0, 1'b0};
    mv[13] = '{4'd11, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_8000_0001, 1'b0};
    mv[14] = '{4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mulout", mulOut, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU table (combinational, same cycle)
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      aluOp = av[i].op; ia = av[i].a; ib = av[i].b;
      #1;
      check($sformatf("alu%0d_64", i), aluOut, av[i].e64);
      check($sformatf("alu%0d_32", i), {32'd0, aluOut32}, {32'd0, av[i].e32});
    end

    // Multiply/divide table
    for (int i = 0; i < 15; i++) begin
      run_mul($sformatf("mul%0d", i), mv[i].op, mv[i].a, mv[i].b, mv[i].exp, mv[i].multi);
    end

    // Hold: no start without en or without newOp
    run_mul("mul_42", 4'd0, 64'd6, 64'd7, 64'd42, 1'b0);
    @(negedge clk);
    en = 1'b0; newOp = 1'b1; mulOp = 4'd0; ia = 64'd3; ib = 64'd3;
    @(posedge clk); #1;
    check("hold_en0", mulOut, 64'd42);
    @(negedge clk);
    en = 1'b1; newOp = 1'b0;
    @(posedge clk); #1;
    check("hold_newop0", mulOut, 64'd42);
    en = 1'b0;

`ifdef ALU_MUL_DIV_EN
    // Request held during a divide: ignored while busy, including on the completion edge,
    // then starts on the following edge.
    @(negedge clk);
    en = 1'b1; newOp = 1'b1; mulOp = 4'd4; ia = -64'sd20; ib = 64'd3;
    @(posedge clk); #1;
    check("held_busy", {63'd0, busy}, 64'd1);
    mulOp = 4'd0; ia = 64'd6; ib = 64'd7;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_cycles", 64'(n), 64'd64);
    check("held_div_res", mulOut, -64'sd6);
    @(posedge clk); #1;
    check("held_next_start", mulOut, 64'd42);
    check("held_next_busy", {63'd0, busy}, 64'd0);
    en = 1'b0;
`endif

    // Reset during a divide
    @(negedge clk);
    en = 1'b1; newOp = 1'b1; mulOp = 4'd4; ia = -64'sd20; ib = 64'd3;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_mulout", mulOut, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_mul("post_rst_mul", 4'd0, 64'd6, 64'd7, 64'd42, 1'b0);
    repeat (70) @(posedge clk);
    #1;
    check("post_rst_hold", mulOut, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul.md
# alu_mul

Integer arithmetic core of the execute stage: a combinational RV64I ALU plus a registered RV64M multiply/divide unit. It takes two 64-bit operands already selected by the execute stage, plus an ALU opcode and an M-extension opcode. It returns a 64-bit ALU result, a 32-bit word-op result and a multiply/divide result. Execute uses `busy` to stall the pipeline while a divide iterates.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `en` in 1 — an M-extension op is requested.
- `newOp` in 1 — qualifies a fresh request. A start happens only on a cycle with `en & newOp & ~busy`.
- `ia` in 64 — operand A.
- `ib` in 64 — operand B.
- `aluOp` in 4 — ALU opcode.
- `mulOp` in 4 — multiply/divide opcode.
- `aluOut` out 64 — 64-bit ALU result, combinational.
- `aluOut32` out 32 — 32-bit ALU result on `ia[31:0]` and `ib[31:0]`, combinational.
- `mulOut` out 64 — multiply/divide result, registered and held until the next completion.
- `busy` out 1 — a divide is in progress.

## Operation
- `aluOp` encoding; each op yields both widths:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed, result 1 or 0), 9 SLTU (unsigned, result 1 or 0).
  - 10–15 produce 0.
- Shift amounts:
  - `aluOut` uses `ib[5:0]`.
  - `aluOut32` uses `ib[4:0]` and shifts only the low 32 bits; SRA replicates bit 31.
- `mulOp` encoding:
  - 0 MUL (low 64 bits), 1 MULH (signed×signed, high), 2 MULHSU (signed×unsigned, high), 3 MULHU (high).
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - 8 MULW; 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW.
  - 13–15 produce 0.
- W ops act on the low 32 bits; the 32-bit result is sign-extended to 64.
- Divide by zero: quotient is all ones, remainder is the dividend. For W ops these are the 32-bit values, then sign-extended.
- Signed overflow (most-negative ÷ −1): quotient is the dividend, remainder is 0.
- Operands are sampled at the start edge; later changes to `ia`, `ib` or `mulOp` do not affect an op in flight.

## Timing
- ALU: purely combinational, zero latency.
- Start edge: the edge on which `en & newOp & ~busy` is sampled high.
- Multiply ops, ops 13–15, and the divide special cases (zero divisor, overflow): `mulOut` is written at the start edge; `busy` stays 0.
- Regular divide/remainder:
  - `busy` goes to 1 at the start edge.
  - A restoring divider runs 64 iterations, one per cycle. All variants use 64 iterations; W operands are pre-extended to 64 bits.
  - `mulOut` is written at the 64th edge after the start edge, and `busy` returns to 0 on that same edge.
- Requests while `busy` = 1 are ignored; no queuing.
- `en` = 0 or `newOp` = 0 means no start, and `mulOut` holds its value.
- Reset: `busy` = 0 and `mulOut` = 0, and any divide in progress is aborted.
- Simultaneous events: if a request arrives on the same edge a divide completes, it is ignored because `busy` was still 1. A new op can start on the following cycle.

## Configuration
- `ALU_MUL_DIV_EN` defined: the iterative divider is present and ops 4–7 and 9–12 behave as specified.
- `ALU_MUL_DIV_EN` undefined: the divider is omitted. Ops 4–7 and 9–12 write `mulOut` = 0 in one cycle like multiplies, and `busy` is tied to 0.

## Structure
- Shared package holds:
  - `aluOp` and `mulOp` enum typedefs with the encodings above.
  - `u64` and `u32` typedefs.
  - `DIV_ITERS` = 64.
- One sub-module, `div_iter`: signed/unsigned restoring divider. Ports: start, operands, signed flag, busy/done, quotient, remainder.
- The ALU and the multiplier stay inline in `alu_mul`.

## Test plan
- SUB with `ia` = 5, `ib` = 7: `aluOut` = 0xFFFF_FFFF_FFFF_FFFE and `aluOut32` = 0xFFFF_FFFE, in the same cycle.
- SRA with `ia` = 0x8000_0000_0000_0000, `ib` = 0x41: `aluOut` = 0xC000_0000_0000_0000 (shift by 1, since only `ib[5:0]` is used). `aluOut32` = 0x0000_0000, since the low 32 bits of `ia` are 0.
- MULH with `ia` = −1, `ib` = −1: `mulOut` = 0 one edge after start and `busy` never rises. MULHU with the same operands: `mulOut` = 0xFFFF_FFFF_FFFF_FFFE.
- DIV with `ia` = −20, `ib` = 3: `busy` is high for 64 cycles, then `mulOut` = −6. A second request during `busy` is ignored. REM with the same operands gives −2.
- DIVU by 0 gives all ones and REMW of 0x8000_0000 by 0xFFFF_FFFF gives 0, both in one cycle with no `busy`.
- Assert `rst` in the middle of a divide: `busy` = 0 and `mulOut` = 0 on the next edge, and a new MUL 6×7 started afterwards returns 42.
